// File: rtl/sys_arr_collector_if.sv
// Result-row stream from the collector to the downstream consumer.
//   out_data  : aligned result row, column j in bits [16j+15:16j]
//   out_valid : out_data/out_last are valid
//   out_ready : consumer accepts the presented row
//   out_last  : presented row is the last row of its matrix
// master = collector side, slave = consumer side.
interface sys_arr_collector_if #(
    parameter int unsigned width_height = 2
) ();
    logic [16*width_height-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sys_arr_collector.sv
// Output-side collector for the weight-stationary systolic array.
// Removes the per-column skew of the bottom-row maccout stream with
// per-column delay lines, buffers realigned rows in a small FIFO and
// presents them over a valid/ready handshake.
// Ports:
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   maccin        : skewed bottom-row sums, column j at bits [16j+15:16j]
//   in_valid      : column 0 of a new row is on maccin this cycle
//   in_last       : row is the last of its matrix (qualified by in_valid)
//   res           : result-row stream (out_data/out_valid/out_ready/out_last)
//   free          : empty FIFO slots (from registered occupancy)
//   overflow      : sticky, set when an aligned row was dropped on a full FIFO
module sys_arr_collector #(
    parameter int unsigned width_height = 2,
    parameter int unsigned depth        = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [16*width_height-1:0]     maccin,
    input  logic                           in_valid,
    input  logic                           in_last,
    sys_arr_collector_if.master            res,
    output logic [$clog2(depth+1)-1:0]     free,
    output logic                           overflow
);

    localparam int unsigned dw    = 16 * width_height;
    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned cnt_w = $clog2(depth + 1);
    localparam int unsigned vdly  = width_height - 1;

    logic [dw-1:0] aligned_row;
    logic          wr_en;
    logic          wr_last;

    // Column j arrives j cycles late; delay it by W-1-j so all columns meet.
    for (genvar j = 0; j < width_height; j++) begin : g_col
        localparam int unsigned stages = width_height - 1 - j;

        if (stages == 0) begin : g_direct
            assign aligned_row[16*j +: 16] = maccin[16*j +: 16];
        end else begin : g_dly
            logic [15:0] sr [stages];

            // Pipelined column delay line
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < int'(stages); i++) begin
                        sr[i] <= '0;
                    end
                end else begin
                    sr[0] <= maccin[16*j +: 16];
                    for (int i = 1; i < int'(stages); i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign aligned_row[16*j +: 16] = sr[stages-1];
        end
    end

    // Valid/last delay line: matches the column-0 path so wr_en lines up
    // with the cycle the whole row is present at the write port.
    if (vdly == 0) begin : g_vdirect
        assign wr_en   = in_valid;
        assign wr_last = in_valid & in_last;
    end else begin : g_vdly
        logic [1:0] vsr [vdly];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < int'(vdly); i++) begin
                    vsr[i] <= '0;
                end
            end else begin
                vsr[0] <= {in_valid & in_last, in_valid};
                for (int i = 1; i < int'(vdly); i++) begin
                    vsr[i] <= vsr[i-1];
                end
            end
        end

        assign wr_en   = vsr[vdly-1][0];
        assign wr_last = vsr[vdly-1][1];
    end

    // FIFO storage: row data plus last flag in the MSB
    logic [dw:0]      mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;

    logic full;
    logic pop;
    logic push_ok;
    logic drop;

    // A same-cycle pop frees the slot, so a push into a full FIFO is taken.
    always_comb begin
        full    = (count == cnt_w'(depth));
        pop     = (count != '0) && res.out_ready;
        push_ok = wr_en && (!full || pop);
        drop    = wr_en && full && !pop;
    end

    // Pointers, occupancy, storage and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < int'(depth); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {wr_last, aligned_row};
                wr_ptr      <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head of FIFO drives the stream; zero when nothing is presented.
    always_comb begin
        res.out_valid = (count != '0);
        res.out_data  = res.out_valid ? mem[rd_ptr][dw-1:0] : '0;
        res.out_last  = res.out_valid ? mem[rd_ptr][dw]     : 1'b0;
        free          = cnt_w'(depth) - count;
    end

endmodule

// File: tb/tb_sys_arr_collector.sv
// Directed testbench for sys_arr_collector (W=2, depth=4).
module tb_sys_arr_collector;

    localparam int unsigned W = 2;
    localparam int unsigned D = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   maccin;
    logic          in_valid;
    logic          in_last;
    logic [2:0]    free;
    logic          overflow;
    logic [15:0]   pend;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sys_arr_collector_if #(.width_height(W)) res ();

    sys_arr_collector #(.width_height(W), .depth(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .maccin   (maccin),
        .in_valid (in_valid),
        .in_last  (in_last),
        .res      (res.master),
        .free     (free),
        .overflow (overflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle: column 0 of this row now, column 1 one cycle later.
    task automatic issue(input logic v, input logic l, input logic [15:0] c0, input logic [15:0] c1);
        in_valid = v;
        in_last  = l;
        maccin   = {pend, c0};
        pend     = c1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] row_word(input int r);
        return {16'hB000 + 16'(r), 16'hA000 + 16'(r)};
    endfunction

    task automatic send(input int r, input logic l);
        issue(1'b1, l, 16'hA000 + 16'(r), 16'hB000 + 16'(r));
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
        pend  = 16'h0;
    endtask

    task automatic drain(input int first, input int n);
        res.out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            check_eq("drain_valid", 64'(res.out_valid), 64'd1);
            check_eq("drain_data", 64'(res.out_data), 64'(row_word(first + k)));
            idle();
        end
        check_eq("drain_empty", 64'(res.out_valid), 64'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic [31:0] bp_exp [6];

        reset         = 1'b1;
        in_valid      = 1'b0;
        in_last       = 1'b0;
        maccin        = '0;
        pend          = '0;
        res.out_ready = 1'b0;
        idle();
        do_reset();

        // Reset state
        check_eq("rst_valid", 64'(res.out_valid), 64'd0);
        check_eq("rst_last", 64'(res.out_last), 64'd0);
        check_eq("rst_data", 64'(res.out_data), 64'd0);
        check_eq("rst_free", 64'(free), 64'd4);
        check_eq("rst_ovf", 64'(overflow), 64'd0);

        // Single row: valid at t+2 with full row
        res.out_ready = 1'b1;
        issue(1'b1, 1'b0, 16'h0011, 16'h0022);
        check_eq("single_t1_valid", 64'(res.out_valid), 64'd0);
        idle();
        check_eq("single_valid", 64'(res.out_valid), 64'd1);
        check_eq("single_data", 64'(res.out_data), 64'h00220011);
        check_eq("single_free", 64'(free), 64'd3);
        idle();
        check_eq("single_free_back", 64'(free), 64'd4);
        check_eq("single_gone", 64'(res.out_valid), 64'd0);

        // Burst of 4 fills the FIFO, 5th row is dropped
        res.out_ready = 1'b0;
        for (int r = 1; r <= 4; r++) send(r, 1'b0);
        idle();
        check_eq("burst_free0", 64'(free), 64'd0);
        check_eq("burst_head", 64'(res.out_data), 64'(row_word(1)));
        check_eq("burst_ovf0", 64'(overflow), 64'd0);
        send(5, 1'b0);
        idle();
        check_eq("burst_ovf1", 64'(overflow), 64'd1);
        check_eq("burst_free_still0", 64'(free), 64'd0);
        drain(1, 4);
        check_eq("burst_ovf_sticky", 64'(overflow), 64'd1);

        // Full plus same-cycle pop: 5th row accepted
        do_reset();
        check_eq("rst2_ovf", 64'(overflow), 64'd0);
        check_eq("rst2_free", 64'(free), 64'd4);
        res.out_ready = 1'b0;
        for (int r = 1; r <= 4; r++) send(r, 1'b0);
        idle();
        check_eq("fullpop_free0", 64'(free), 64'd0);
        send(5, 1'b0);
        res.out_ready = 1'b1;
        idle();
        res.out_ready = 1'b0;
        check_eq("fullpop_ovf", 64'(overflow), 64'd0);
        check_eq("fullpop_free", 64'(free), 64'd0);
        check_eq("fullpop_head", 64'(res.out_data), 64'(row_word(2)));
        drain(2, 4);

        // Last flag only with row 3
        do_reset();
        res.out_ready = 1'b1;
        send(21, 1'b0);
        send(22, 1'b0);
        check_eq("last_r1_data", 64'(res.out_data), 64'(row_word(21)));
        check_eq("last_r1_last", 64'(res.out_last), 64'd0);
        send(23, 1'b1);
        check_eq("last_r2_data", 64'(res.out_data), 64'(row_word(22)));
        check_eq("last_r2_last", 64'(res.out_last), 64'd0);
        idle();
        check_eq("last_r3_data", 64'(res.out_data), 64'(row_word(23)));
        check_eq("last_r3_last", 64'(res.out_last), 64'd1);
        idle();
        check_eq("last_after_valid", 64'(res.out_valid), 64'd0);
        check_eq("last_after_last", 64'(res.out_last), 64'd0);

        // Backpressure: out_ready toggles; head row must stay put while stalled
        do_reset();
        for (int k = 0; k < 6; k++) bp_exp[k] = row_word(31 + k);
        idx = 0;
        for (int i = 0; i < 30; i++) begin
            res.out_ready = i[0];
            if (res.out_valid) begin
                if (idx < 6) begin
                    check_eq("bp_data", 64'(res.out_data), 64'(bp_exp[idx]));
                end else begin
                    check_eq("bp_extra_row", 64'(res.out_valid), 64'd0);
                end
                if (res.out_ready) idx++;
            end
            if (i < 6) send(31 + i, 1'b0);
            else idle();
        end
        check_eq("bp_count", 64'(idx), 64'd6);
        check_eq("bp_ovf", 64'(overflow), 64'd0);
        check_eq("bp_free", 64'(free), 64'd4);

        // Reset mid-burst: 2 rows buffered, 1 in the delay line
        res.out_ready = 1'b0;
        send(41, 1'b0);
        send(42, 1'b0);
        send(43, 1'b0);
        check_eq("mid_free", 64'(free), 64'd2);
        do_reset();
        check_eq("mid_rst_valid", 64'(res.out_valid), 64'd0);
        check_eq("mid_rst_free", 64'(free), 64'd4);
        check_eq("mid_rst_ovf", 64'(overflow), 64'd0);
        idle();
        idle();
        check_eq("mid_inflight_lost", 64'(res.out_valid), 64'd0);
        check_eq("mid_free_after", 64'(free), 64'd4);
        issue(1'b1, 1'b0, 16'h1234, 16'h5678);
        check_eq("mid_new_t1", 64'(res.out_valid), 64'd0);
        idle();
        check_eq("mid_new_valid", 64'(res.out_valid), 64'd1);
        check_eq("mid_new_data", 64'(res.out_data), 64'h56781234);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
